ex_mem_skid: RTL and testbench
==============================

Name: ex_mem_skid

Overview:
- Execute-to-memory boundary register placed directly downstream of the ALU.
- Captures ALU result, nonzero flag, store data, destination register and control bits into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Resolves conditional branches from the registered ALU flag and presents the redirect to fetch.
- Absorbs memory-stage backpressure without a combinational ready path back into execute.

Parameters:
- DATA_W, 32, width of ALU result, store data and branch target.
- REG_W, 5, width of destination register index.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ValidE  in  1  execute-side entry valid.
- ReadyE  out  1  buffer can accept; registered.
- FlushE  in  1  discard all buffered entries (mispredict/exception).
- ALUOutE  in  DATA_W  ALU result.
- ZeroE  in  1  ALU flag, reduction-OR of result (1 = result nonzero).
- WriteDataE  in  DATA_W  store data.
- WriteRegE  in  REG_W  destination register.
- RegWriteE, MemWriteE, MemtoRegE, BranchE  in  1 each  control bits.
- PCBranchE  in  DATA_W  branch target.
- ValidM  out  1  head entry valid.
- ReadyM  in  1  memory stage accepts head.
- ALUOutM, WriteDataM  out  DATA_W  head payload.
- WriteRegM  out  REG_W  head destination.
- RegWriteM, MemWriteM, MemtoRegM  out  1 each  head control bits, forced 0 when ValidM=0.
- PCSrcM  out  1  taken-branch redirect pulse.
- PCBranchM  out  DATA_W  redirect target.

Behaviour:
- Handshake timing:
  - accept = ValidE & ReadyE.
  - handoff = ValidM & ReadyM.
  - Payload is held stable while ValidM=1 and ReadyM=0.
- FSM over occupancy:
  - EMPTY: ReadyE=1, ValidM=0. On accept, go to ONE.
  - ONE: ReadyE=1, ValidM=1.
    - accept & handoff: new entry becomes head; stay in ONE.
    - accept only: new entry goes to skid; go to TWO.
    - handoff only: go to EMPTY.
  - TWO: ReadyE=0, ValidM=1. On handoff, skid moves to head; go to ONE.
- ReadyE comes from a flop and has zero combinational dependence on ReadyM.
- Latency is 1 cycle from accept to ValidM when the buffer is empty. Throughput is 1 entry/cycle while ReadyM=1.
- Ordering is strictly FIFO; head is always the oldest entry.
- Flush:
  - FlushE=1 at a clock edge sends the FSM to EMPTY and discards both entries.
  - A same-cycle accept is dropped.
  - A same-cycle handoff completes; the consumer already sampled it.
  - FlushE has priority over every other event.
- Branch resolution:
  - PCSrcM = handoff & BranchM & ~ZeroM, combinational from the head entry.
  - Branch is taken when the ALU result is zero (beq equal / bne unequal encodings).
  - PCSrcM is asserted only in the handoff cycle, so there is exactly one pulse per branch.
  - PCBranchM = head target.
- Non-branch entries never assert PCSrcM.
- Reset (asynchronous, any cycle, including mid-transfer):
  - FSM goes to EMPTY; ReadyE=0 while rst_n=0, then 1 from the first edge after release.
  - ValidM=0 and PCSrcM=0.
  - All payload registers and all control outputs are 0.

Optional Feature:
- Macro: EX_MEM_SKID_STATS_EN.
- Defined: adds output ports StatAccept, StatStall and StatFlush, each 32 bits.
  - StatAccept counts accepts.
  - StatStall counts cycles with ValidM & ~ReadyM.
  - StatFlush counts cycles with FlushE=1 while the FSM is not EMPTY.
  - All three wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, then accept ALUOutE=0x00000005, WriteRegE=3, RegWriteE=1 with ReadyM=1 -> next cycle ValidM=1, ALUOutM=0x5, WriteRegM=3, RegWriteM=1; ReadyE stays 1.
- ReadyM=0, accept 0xA then 0xB -> ReadyE=0 after the second accept. Raise ReadyM -> 0xA then 0xB in consecutive cycles; ReadyE returns to 1 after 0xA's handoff.
- BranchE=1, ZeroE=0, PCBranchE=0x00400020, ReadyM=0 for 3 cycles, then ReadyM=1 -> PCSrcM=0 while stalled, exactly one PCSrcM=1 with PCBranchM=0x00400020 at handoff. Repeat with ZeroE=1 -> PCSrcM never asserts.
- TWO state with FlushE=1 plus a simultaneous accept -> next cycle ValidM=0, ReadyE=1, no entry emerges; a following accept of 0x7 emerges alone.
- Drop rst_n mid-stall in TWO -> ValidM=0, MemWriteM=0, PCSrcM=0 immediately without a clock edge. After release the first accept has 1-cycle latency.
- With EX_MEM_SKID_STATS_EN: 4 accepts, 2 stall cycles, 1 flush in a non-EMPTY state -> StatAccept=4, StatStall=2, StatFlush=1.

Source files
------------

// File: rtl/ex_mem_skid.sv
// Execute-to-memory boundary: a 2-entry skid buffer with handshakes on both sides and branch resolution at handoff.
// Optional event counters are enabled with the EX_MEM_SKID_STATS_EN macro.
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    // execute side
    input  logic              ValidE,
    output logic              ReadyE,
    input  logic              FlushE,
    input  logic [DATA_W-1:0] ALUOutE,
    input  logic              ZeroE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [REG_W-1:0]  WriteRegE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              MemtoRegE,
    input  logic              BranchE,
    input  logic [DATA_W-1:0] PCBranchE,
    // memory side
    output logic              ValidM,
    input  logic              ReadyM,
    output logic [DATA_W-1:0] ALUOutM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [REG_W-1:0]  WriteRegM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              MemtoRegM,
    output logic              PCSrcM,
    output logic [DATA_W-1:0] PCBranchM
`ifdef EX_MEM_SKID_STATS_EN
    ,
    output logic [31:0]       StatAccept,
    output logic [31:0]       StatStall,
    output logic [31:0]       StatFlush
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] alu_out;
        logic              zero;
        logic [DATA_W-1:0] write_data;
        logic [REG_W-1:0]  write_reg;
        logic              reg_write;
        logic              mem_write;
        logic              memto_reg;
        logic              branch;
        logic [DATA_W-1:0] pc_branch;
    } entry_t;

    state_e state_q, state_d;
    logic   ready_e_q, ready_e_d;
    logic   valid_m_q, valid_m_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   accept;
    logic   handoff;

    assign accept  = ValidE & ready_e_q;
    assign handoff = valid_m_q & ReadyM;

    always_comb begin
        in_entry = '{
            alu_out:    ALUOutE,
            zero:       ZeroE,
            write_data: WriteDataE,
            write_reg:  WriteRegE,
            reg_write:  RegWriteE,
            mem_write:  MemWriteE,
            memto_reg:  MemtoRegE,
            branch:     BranchE,
            pc_branch:  PCBranchE
        };
    end

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        if (FlushE) begin
            // Flush beats accept; a same-cycle handoff was already sampled downstream.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && handoff) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = TWO;
                    end else if (handoff) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (handoff) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Handshake flags are registered copies of the next occupancy, so ReadyE never sees ReadyM combinationally.
        ready_e_d = (state_d != TWO);
        valid_m_d = (state_d != EMPTY);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    // NOTE: payload registers are reset too, so outputs read as zero during and right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            ready_e_q <= 1'b0;
            valid_m_q <= 1'b0;
            head_q    <= '0;
            skid_q    <= '0;
        end else begin
            state_q   <= state_d;
            ready_e_q <= ready_e_d;
            valid_m_q <= valid_m_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
        end
    end

    assign ReadyE     = ready_e_q;
    assign ValidM     = valid_m_q;
    assign ALUOutM    = head_q.alu_out;
    assign WriteDataM = head_q.write_data;
    assign WriteRegM  = head_q.write_reg;
    assign RegWriteM  = valid_m_q & head_q.reg_write;
    assign MemWriteM  = valid_m_q & head_q.mem_write;
    assign MemtoRegM  = valid_m_q & head_q.memto_reg;
    assign PCBranchM  = head_q.pc_branch;

    // Zero flag is 1 for a nonzero result, so a branch is taken when it is clear.
    assign PCSrcM     = handoff & head_q.branch & ~head_q.zero;

`ifdef EX_MEM_SKID_STATS_EN
    logic [31:0] stat_accept_q, stat_accept_d;
    logic [31:0] stat_stall_q,  stat_stall_d;
    logic [31:0] stat_flush_q,  stat_flush_d;

    always_comb begin
        stat_accept_d = stat_accept_q;
        stat_stall_d  = stat_stall_q;
        stat_flush_d  = stat_flush_q;
        if (accept) begin
            stat_accept_d = stat_accept_q + 32'd1;
        end
        if (valid_m_q && !ReadyM) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
        if (FlushE && (state_q != EMPTY)) begin
            stat_flush_d = stat_flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accept_q <= '0;
            stat_stall_q  <= '0;
            stat_flush_q  <= '0;
        end else begin
            stat_accept_q <= stat_accept_d;
            stat_stall_q  <= stat_stall_d;
            stat_flush_q  <= stat_flush_d;
        end
    end

    assign StatAccept = stat_accept_q;
    assign StatStall  = stat_stall_q;
    assign StatFlush  = stat_flush_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: stimulus pushes expected entries, a negedge monitor pops and compares at each handoff.
module tb_ex_mem_skid;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic        br;
        logic        zr;
        logic [31:0] pcb;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              ValidE;
    logic              ReadyE;
    logic              FlushE;
    logic [DATA_W-1:0] ALUOutE;
    logic              ZeroE;
    logic [DATA_W-1:0] WriteDataE;
    logic [REG_W-1:0]  WriteRegE;
    logic              RegWriteE;
    logic              MemWriteE;
    logic              MemtoRegE;
    logic              BranchE;
    logic [DATA_W-1:0] PCBranchE;
    logic              ValidM;
    logic              ReadyM;
    logic [DATA_W-1:0] ALUOutM;
    logic [DATA_W-1:0] WriteDataM;
    logic [REG_W-1:0]  WriteRegM;
    logic              RegWriteM;
    logic              MemWriteM;
    logic              MemtoRegM;
    logic              PCSrcM;
    logic [DATA_W-1:0] PCBranchM;
`ifdef EX_MEM_SKID_STATS_EN
    logic [31:0]       StatAccept;
    logic [31:0]       StatStall;
    logic [31:0]       StatFlush;
`endif

    ex_mem_skid #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ValidE     (ValidE),
        .ReadyE     (ReadyE),
        .FlushE     (FlushE),
        .ALUOutE    (ALUOutE),
        .ZeroE      (ZeroE),
        .WriteDataE (WriteDataE),
        .WriteRegE  (WriteRegE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .MemtoRegE  (MemtoRegE),
        .BranchE    (BranchE),
        .PCBranchE  (PCBranchE),
        .ValidM     (ValidM),
        .ReadyM     (ReadyM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .WriteRegM  (WriteRegM),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .PCSrcM     (PCSrcM),
        .PCBranchM  (PCBranchM)
`ifdef EX_MEM_SKID_STATS_EN
        ,
        .StatAccept (StatAccept),
        .StatStall  (StatStall),
        .StatFlush  (StatFlush)
`endif
    );

    int   total = 0;
    int   bad   = 0;
    int   pulse_cnt = 0;
    vec_t exp_q[$];
    vec_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                                input logic rw, input logic mw, input logic m2r,
                                input logic br, input logic zr, input logic [31:0] pcb);
        vec_t v;
        v.alu = alu; v.wd = wd; v.wr = wr; v.rw = rw; v.mw = mw;
        v.m2r = m2r; v.br = br; v.zr = zr; v.pcb = pcb;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ALUOutE    = v.alu;
        WriteDataE = v.wd;
        WriteRegE  = v.wr;
        RegWriteE  = v.rw;
        MemWriteE  = v.mw;
        MemtoRegE  = v.m2r;
        BranchE    = v.br;
        ZeroE      = v.zr;
        PCBranchE  = v.pcb;
    endtask

    // Offer one entry until accepted; push its expected image only if it should reach the memory side.
    task automatic send(input vec_t v, input bit expect_out);
        bit ok;
        ok = 1'b0;
        drive(v);
        ValidE = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = ReadyE;
            @(posedge clk);
            #1;
        end
        ValidE = 1'b0;
        if (!ok) begin
            check("send_timeout", 32'd0, 32'd1);
        end else if (expect_out) begin
            exp_q.push_back(v);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic flush_cycle(input bit with_valid);
        FlushE = 1'b1;
        ValidE = with_valid;
        drive(mk(32'hDEAD_BEEF, 32'h1, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0));
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        ValidE = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the head against the scoreboard on every handoff.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ValidM && ReadyM) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_handoff", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("alu_out",    ALUOutM,            mon_e.alu);
                    check("write_data", WriteDataM,         mon_e.wd);
                    check("write_reg",  32'(WriteRegM),     32'(mon_e.wr));
                    check("reg_write",  32'(RegWriteM),     32'(mon_e.rw));
                    check("mem_write",  32'(MemWriteM),     32'(mon_e.mw));
                    check("memto_reg",  32'(MemtoRegM),     32'(mon_e.m2r));
                    check("pcsrc",      32'(PCSrcM),        32'(mon_e.br & ~mon_e.zr));
                    if (mon_e.br) check("pc_branch", PCBranchM, mon_e.pcb);
                end
            end else begin
                check("pcsrc_idle", 32'(PCSrcM), 32'd0);
            end
            if (!ValidM) check("ctrl_idle", 32'({RegWriteM, MemWriteM, MemtoRegM}), 32'd0);
            if (PCSrcM) pulse_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        rst_n  = 1'b0;
        ValidE = 1'b0;
        FlushE = 1'b0;
        ReadyM = 1'b0;
        drive('0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready_e", 32'(ReadyE),  32'd0);
        check("rst_valid_m", 32'(ValidM),  32'd0);
        check("rst_pcsrc",   32'(PCSrcM),  32'd0);
        check("rst_alu_out", ALUOutM,      32'd0);
        check("rst_reg",     32'(WriteRegM), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("ready_e_before_edge", 32'(ReadyE), 32'd0);
        @(posedge clk);
        #1;
        check("ready_e_after_edge", 32'(ReadyE), 32'd1);

        // Single entry, one-cycle latency
        ReadyM = 1'b1;
        send(mk(32'h5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0), 1'b1);
        check("lat1_valid_m", 32'(ValidM), 32'd1);
        check("lat1_ready_e", 32'(ReadyE), 32'd1);
        drain();

        // Fill to TWO under backpressure, then drain in order
        ReadyM = 1'b0;
        send(mk(32'hA, 32'h11, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0), 1'b1);
        send(mk(32'hB, 32'h22, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0), 1'b1);
        check("two_ready_e", 32'(ReadyE), 32'd0);
        check("two_head",    ALUOutM,     32'hA);
        @(posedge clk);
        #1;
        check("stall_hold",  ALUOutM,     32'hA);
        ReadyM = 1'b1;
        @(posedge clk);
        #1;
        check("after_a_ready_e", 32'(ReadyE), 32'd1);
        check("after_a_head",    ALUOutM,     32'hB);
        drain();

        // Taken branch: one pulse at handoff only
        p0 = pulse_cnt;
        ReadyM = 1'b0;
        send(mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0020), 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("br_stall_pcsrc", 32'(PCSrcM), 32'd0);
        ReadyM = 1'b1;
        drain();
        check("br_taken_pulses", 32'(pulse_cnt - p0), 32'd1);

        // Not-taken branch: nonzero result never redirects
        ReadyM = 1'b0;
        send(mk(32'h4, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0040), 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        ReadyM = 1'b1;
        drain();
        check("br_nt_pulses", 32'(pulse_cnt - p0), 32'd1);

        // Flush in TWO with an offered entry
        ReadyM = 1'b0;
        send(mk(32'h61, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0), 1'b0);
        send(mk(32'h62, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0), 1'b0);
        check("pre_flush_ready_e", 32'(ReadyE), 32'd0);
        flush_cycle(1'b1);
        check("flush2_valid_m", 32'(ValidM), 32'd0);
        check("flush2_ready_e", 32'(ReadyE), 32'd1);
        ReadyM = 1'b1;
        send(mk(32'h7, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0), 1'b1);
        drain();

        // Flush in ONE drops a same-cycle accept
        ReadyM = 1'b0;
        send(mk(32'h63, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0), 1'b0);
        flush_cycle(1'b1);
        check("flush1_valid_m", 32'(ValidM), 32'd0);
        @(posedge clk);
        #1;
        check("flush1_still_empty", 32'(ValidM), 32'd0);
        ReadyM = 1'b1;
        send(mk(32'h8, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0), 1'b1);
        drain();

        // Asynchronous reset mid-stall in TWO
        ReadyM = 1'b0;
        send(mk(32'h71, 32'h5, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0), 1'b0);
        send(mk(32'h72, 32'h6, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0), 1'b0);
        check("pre_rst_mem_write", 32'(MemWriteM), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid_m",   32'(ValidM),    32'd0);
        check("async_mem_write", 32'(MemWriteM), 32'd0);
        check("async_pcsrc",     32'(PCSrcM),    32'd0);
        check("async_ready_e",   32'(ReadyE),    32'd0);
        check("async_alu_out",   ALUOutM,        32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ReadyM = 1'b1;
        send(mk(32'h9, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0), 1'b1);
        check("post_rst_latency", 32'(ValidM), 32'd1);
        drain();

        // Counter scenario: 4 accepts, 2 stall cycles, 1 non-empty flush (with same-cycle handoff)
        do_reset();
        ReadyM = 1'b0;
        send(mk(32'h81, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0), 1'b1);
        send(mk(32'h82, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0), 1'b1);
        @(posedge clk);
        #1;
        ReadyM = 1'b1;
        drain();
        ReadyM = 1'b0;
        send(mk(32'h83, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0), 1'b1);
        ReadyM = 1'b1;
        flush_cycle(1'b0);
        check("flush_handoff_done", 32'(exp_q.size()), 32'd0);
        check("flush_hs_valid_m",   32'(ValidM),       32'd0);
        send(mk(32'h84, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0), 1'b1);
        drain();
`ifdef EX_MEM_SKID_STATS_EN
        check("stat_accept", StatAccept, 32'd4);
        check("stat_stall",  StatStall,  32'd2);
        check("stat_flush",  StatFlush,  32'd1);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
